// File: rtl/i2c_reg_arbiter_if.sv
// i2c_reg_arbiter_if: signal bundle for the I2C/host register-bus arbiter
// slave modport is the arbiter's view:
//   inputs:  I2C slave request fields, host request fields, mem_rdata/mem_ready
//   outputs: i2c_rd_data/i2c_ovf, host_ack/host_rdata, mem_en/mem_we/mem_addr/mem_wdata, err
// master modport is the surrounding system's view (the I2C slave, the host and the memory).
interface i2c_reg_arbiter_if;
  logic       i2c_req;
  logic       i2c_wr1rd0;
  logic [7:0] i2c_addr;
  logic [7:0] i2c_wr_data;
  logic [7:0] i2c_rd_data;
  logic       i2c_ovf;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       err;
  modport slave (
    input  i2c_req, i2c_wr1rd0, i2c_addr, i2c_wr_data, host_req, host_we, host_addr, host_wdata,
           mem_rdata, mem_ready,
    output i2c_rd_data, i2c_ovf, host_ack, host_rdata, mem_en, mem_we, mem_addr, mem_wdata, err
  );
  modport master (
    output i2c_req, i2c_wr1rd0, i2c_addr, i2c_wr_data, host_req, host_we, host_addr, host_wdata,
           mem_rdata, mem_ready,
    input  i2c_rd_data, i2c_ovf, host_ack, host_rdata, mem_en, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter: round-robin sharing of a single-port register bus between an I2C slave and a host
// Ports:
//   clk   - block clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - i2c_reg_arbiter_if.slave: I2C request/capture fields, host level-request port, mem_* bus, err
// Optional feature: define I2C_ARB_TIMEOUT_EN to abort an access after TIMEOUT cycles without
// mem_ready (read data forced to 8'hFF, sticky err set); otherwise ACCESS waits indefinitely.
module i2c_reg_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  i2c_reg_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARB, ACCESS, DONE} state_t;
  state_t     r_state, w_next;
  logic [1:0] r_sync;
  logic       r_sync_d, r_i2c_pend, r_i2c_we, r_owner, r_last, r_mem_we, r_ovf;
  logic [7:0] r_i2c_addr, r_i2c_wdata, r_mem_addr, r_mem_wdata, r_i2c_rd, r_host_rd;
  logic [7:0] w_rdata;
  logic       w_edge, w_any, w_i2c_win, w_to, w_done;
  assign w_edge = r_sync[1] & ~r_sync_d;
  assign w_any  = r_i2c_pend | bus.host_req;
  // r_owner/r_last: 1 = I2C, 0 = host; a tie goes to whoever was not granted last
  assign w_i2c_win = r_i2c_pend & (~bus.host_req | ~r_last);
  assign w_done    = bus.mem_ready | w_to;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  // r_cnt counts completed ACCESS cycles, so the TIMEOUT-th ACCESS cycle gives up
  assign w_to    = r_state == ACCESS && !bus.mem_ready && r_cnt == CW'(TIMEOUT - 1);
  assign w_rdata = w_to ? 8'hFF : bus.mem_rdata;
  assign bus.err = r_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= r_state == ACCESS ? r_cnt + CW'(1) : '0;
      r_err <= r_err | w_to;
    end
`else
  assign w_to    = 1'b0;
  assign w_rdata = bus.mem_rdata;
  assign bus.err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE   ? (w_any ? ARB : IDLE) :
             r_state == ARB    ? (w_any ? ACCESS : IDLE) :
             r_state == ACCESS ? (w_done ? DONE : ACCESS) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync      <= 2'b00;
      r_sync_d    <= 1'b0;
      r_i2c_pend  <= 1'b0;
      r_i2c_we    <= 1'b0;
      r_i2c_addr  <= 8'h00;
      r_i2c_wdata <= 8'h00;
      r_ovf       <= 1'b0;
      r_owner     <= 1'b0;
      r_last      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 8'h00;
      r_mem_wdata <= 8'h00;
      r_i2c_rd    <= 8'hFF;
      r_host_rd   <= 8'h00;
    end else begin
      r_sync   <= {r_sync[0], bus.i2c_req};
      r_sync_d <= r_sync[1];
      // pend stays high through DONE, so it also covers an I2C access in flight
      if (w_edge && r_i2c_pend) r_ovf <= 1'b1;
      if (w_edge && !r_i2c_pend) begin
        r_i2c_pend  <= 1'b1;
        r_i2c_we    <= bus.i2c_wr1rd0;
        r_i2c_addr  <= bus.i2c_addr;
        r_i2c_wdata <= bus.i2c_wr_data;
      end
      if (r_state == ARB) begin
        r_owner     <= w_i2c_win;
        r_mem_we    <= w_i2c_win ? r_i2c_we : bus.host_we;
        r_mem_addr  <= w_i2c_win ? r_i2c_addr : bus.host_addr;
        r_mem_wdata <= w_i2c_win ? r_i2c_wdata : bus.host_wdata;
      end
      // read results land on the ACCESS->DONE edge so host_rdata is valid with host_ack
      if (r_state == ACCESS && w_done && !r_mem_we && r_owner) r_i2c_rd <= w_rdata;
      if (r_state == ACCESS && w_done && !r_mem_we && !r_owner) r_host_rd <= w_rdata;
      if (r_state == DONE) begin
        r_last <= r_owner;
        if (r_owner) r_i2c_pend <= 1'b0;
      end
    end
  assign bus.mem_en      = r_state == ACCESS;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.host_ack    = r_state == DONE && !r_owner;
  assign bus.host_rdata  = r_host_rd;
  assign bus.i2c_rd_data = r_i2c_rd;
  assign bus.i2c_ovf     = r_ovf;
endmodule
